// File: rtl/sha_ctrl_pkg.sv
// Shared types and defaults for the nonce sweep controller.
package sha_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, COLLECT, CHECK, FINISH} state_t;

  localparam int DEF_BATCH   = 16;
  localparam int DEF_TIMEOUT = 256;

  // One bit wider than a nonce so a carry past 2^32 stays visible.
  typedef logic [32:0] nsum_t;

  function automatic nsum_t nonce_add(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Controller <-> shared SHA-256 core link: pass launch/abort and result stream.
interface nonce_sweep_ctrl_if;
  logic        core_start;
  logic [31:0] core_nonce_base;
  logic        core_abort;
  logic        res_valid;
  logic [31:0] res_h0;

  modport master (output core_start, core_nonce_base, core_abort, input res_valid, res_h0);
  modport slave  (input core_start, core_nonce_base, core_abort, output res_valid, res_h0);
endinterface

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a nonce range through the shared hash core in BATCH-sized passes and
// reports the lowest nonce whose H0 falls below target.
module nonce_sweep_ctrl
  import sha_ctrl_pkg::*;
#(
  parameter int BATCH   = DEF_BATCH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        nonce_base,
  input  logic [31:0]        nonce_limit,
  input  logic [31:0]        target,
  nonce_sweep_ctrl_if.master core,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [31:0]        found_nonce,
  output logic               error,
  output logic [15:0]        batches_run
);
  localparam int IW = $clog2(BATCH);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        state, nxt;
  logic [31:0]   lim, tgt, cur_base;
  logic [IW-1:0] res_idx;
  logic [WW-1:0] wdog;
  logic          kill;
  logic          go, tmo, last_res, hit, final_pass;
  nsum_t         res_nonce, next_base;

  always_comb begin
    go         = start && !abort;
    res_nonce  = nonce_add(cur_base, 32'(res_idx));
    next_base  = nonce_add(cur_base, 32'(BATCH));
    last_res   = core.res_valid && (res_idx == IW'(BATCH - 1));
    tmo        = !core.res_valid && (wdog == WW'(TIMEOUT - 1));
    hit        = (state == COLLECT) && core.res_valid && !abort && !found &&
                 (core.res_h0 < tgt) && (res_nonce <= {1'b0, lim});
    final_pass = found || (next_base > {1'b0, lim});
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (go) nxt = (nonce_limit < nonce_base) ? FINISH : ISSUE;
      ISSUE:   nxt = abort ? FINISH : COLLECT;
      COLLECT: if (abort || tmo) nxt = FINISH;
               else if (last_res) nxt = CHECK;
      CHECK:   nxt = (abort || final_pass) ? FINISH : ISSUE;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    core.core_start      = (state == ISSUE);
    core.core_abort      = (state == FINISH) && kill;
    core.core_nonce_base = cur_base;
    busy                 = (state != IDLE);
    done                 = (state == FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lim         <= '0;
      tgt         <= '0;
      cur_base    <= '0;
      res_idx     <= '0;
      wdog        <= '0;
      kill        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      error       <= 1'b0;
      batches_run <= '0;
    end else begin
      // kill marks a FINISH reached by abort or watchdog, so the core is told to drop its pass
      kill <= (state == ISSUE || state == COLLECT || state == CHECK) &&
              (abort || (state == COLLECT && tmo));
      case (state)
        IDLE: if (go) begin
          lim         <= nonce_limit;
          tgt         <= target;
          cur_base    <= nonce_base;
          found       <= 1'b0;
          found_nonce <= '0;
          error       <= 1'b0;
          batches_run <= '0;
        end
        ISSUE: begin
          res_idx <= '0;
          wdog    <= '0;
        end
        COLLECT: begin
          if (core.res_valid) begin
            res_idx <= res_idx + IW'(1);
            wdog    <= '0;
          end else begin
            wdog <= wdog + WW'(1);
          end
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= res_nonce[31:0];
          end
          if (tmo && !abort) error <= 1'b1;
        end
        CHECK: begin
          if (batches_run != 16'hFFFF) batches_run <= batches_run + 16'd1;
          if (!abort && !final_pass) cur_base <= next_base[31:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed + randomized bench: cycle-level core model, range-level sweep reference.
module tb_nonce_sweep_ctrl;
  localparam int BATCH   = 16;
  localparam int TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] nonce_base, nonce_limit, target;
  logic        busy, done, found, error;
  logic [31:0] found_nonce;
  logic [15:0] batches_run;

  nonce_sweep_ctrl_if cif();

  nonce_sweep_ctrl #(.BATCH(BATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nonce_base(nonce_base), .nonce_limit(nonce_limit), .target(target),
    .core(cif), .busy(busy), .done(done), .found(found),
    .found_nonce(found_nonce), .error(error), .batches_run(batches_run)
  );

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // hash stand-in: forced hit nonce, pseudo-random mix, or never-hit
  bit          hit_en = 0, rnd_h = 0;
  logic [31:0] hit_n = 0, hseed = 0;

  function automatic logic [31:0] h0f(input logic [31:0] n);
    logic [31:0] x;
    if (hit_en && n == hit_n) return 32'h0000_0800;
    if (!rnd_h) return 32'hFFFF_FFFF;
    x = n ^ hseed;
    x = x * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA6B;
    x = x ^ (x >> 13);
    return x;
  endfunction

  // reference: walk the range pass by pass with wide arithmetic
  logic [31:0] exp_bases[$];
  bit          exp_found;
  logic [31:0] exp_fn;
  int          exp_br;

  task automatic model(input logic [31:0] b, input logic [31:0] l, input logic [31:0] t);
    longint unsigned pb, n;
    exp_bases.delete();
    exp_found = 0; exp_fn = 0; exp_br = 0;
    if (l < b) return;
    pb = longint'(b);
    forever begin
      exp_bases.push_back(pb[31:0]);
      exp_br++;
      for (int i = 0; i < BATCH; i++) begin
        n = pb + longint'(i);
        if (!exp_found && n <= longint'(l) && h0f(n[31:0]) < t) begin
          exp_found = 1; exp_fn = n[31:0];
        end
      end
      if (exp_found || pb + BATCH > longint'(l)) break;
      pb += BATCH;
    end
  endtask

  // core model: one result per cycle at most, random gaps, optional stall
  int          core_idx = 0, stall_at = BATCH, gap_pct = 30;
  bit          core_act = 0;
  logic [31:0] core_pb = 0;

  initial begin
    cif.res_valid = 1'b0;
    cif.res_h0    = '0;
    forever begin
      @(posedge clk); #1;
      cif.res_valid = 1'b0;
      if (reset || cif.core_abort || !busy) core_act = 0;
      else if (cif.core_start) begin
        core_act = 1; core_idx = 0; core_pb = cif.core_nonce_base;
      end else if (core_act && core_idx < BATCH && core_idx < stall_at &&
                   $urandom_range(0, 99) >= gap_pct) begin
        cif.res_valid = 1'b1;
        cif.res_h0    = h0f(core_pb + 32'(core_idx));
        core_idx++;
      end
    end
  end

  longint      cyc = 0, last_rv = 0, err_edge = 0;
  int          done_cnt = 0, abort_cnt = 0;
  bit          err_seen = 0;
  logic [31:0] obs_bases[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cif.res_valid) last_rv <= cyc;
  end

  initial forever begin
    @(posedge clk); #1;
    if (cif.core_start) obs_bases.push_back(cif.core_nonce_base);
    if (done) done_cnt++;
    if (cif.core_abort) abort_cnt++;
    if (error && !err_seen) begin err_seen = 1; err_edge = cyc - 1; end
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] l, input logic [31:0] t);
    @(posedge clk); #1;
    nonce_base = b; nonce_limit = l; target = t; start = 1;
    @(posedge clk); #1;
    start = 0;
    nonce_base = $urandom; nonce_limit = $urandom; target = $urandom;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) begin @(posedge clk); #2; end
    chk("done_pulse", 64'(done_cnt - d0), 1);
  endtask

  task automatic run_sweep(input logic [31:0] b, input logic [31:0] l, input logic [31:0] t,
                           input bit mid_start);
    int d0;
    model(b, l, t);
    obs_bases.delete();
    d0 = done_cnt;
    do_start(b, l, t);
    if (mid_start) begin
      repeat (5) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
    end
    wait_done(d0, 20000);
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("found", found, exp_found);
    chk("found_nonce", found_nonce, exp_fn);
    chk("batches_run", batches_run, exp_br);
    chk("error", error, 0);
    chk("num_passes", obs_bases.size(), exp_bases.size());
    for (int i = 0; i < obs_bases.size() && i < exp_bases.size(); i++)
      chk($sformatf("pass_base%0d", i), obs_bases[i], exp_bases[i]);
  endtask

  initial begin
    logic [31:0] b, l, t;
    int span, d0, a0;
    bit seen;
    reset = 1; start = 0; abort = 0;
    nonce_base = 0; nonce_limit = 0; target = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_start", cif.core_start, 0);
    chk("rst_core_abort", cif.core_abort, 0);
    chk("rst_core_base", cif.core_nonce_base, 0);
    chk("rst_found", found, 0);
    chk("rst_found_nonce", found_nonce, 0);
    chk("rst_error", error, 0);
    chk("rst_batches", batches_run, 0);
    reset = 0;

    // two full passes, no hits
    run_sweep(32'd0, 32'd31, 32'd0, 0);
    // single hit in second pass
    hit_en = 1; hit_n = 32'd121;
    run_sweep(32'd100, 32'd1000, 32'h1000, 0);
    // top-of-range: 33-bit carry ends the sweep
    hit_en = 0;
    run_sweep(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h1000, 0);
    // hit beyond the limit is discarded
    hit_en = 1; hit_n = 32'd9;
    run_sweep(32'd0, 32'd5, 32'h1000, 0);
    // empty range goes straight to FINISH
    hit_en = 0;
    run_sweep(32'd200, 32'd100, 32'hFFFF_FFFF, 0);

    // abort on the 3rd result; earlier hit must survive
    hit_en = 1; hit_n = 32'd1001; gap_pct = 20;
    do_start(32'd1000, 32'd5000, 32'h1000);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #2;
      if (cif.res_valid && core_idx == 3) seen = 1;
    end
    chk("abort_window", seen, 1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_done", done, 1);
    chk("abort_core_abort", cif.core_abort, 1);
    @(posedge clk); #1;
    chk("abort_idle", busy, 0);
    chk("abort_batches", batches_run, 0);
    chk("abort_found", found, 1);
    chk("abort_found_nonce", found_nonce, 32'd1001);
    chk("abort_error", error, 0);

    // abort together with start in IDLE
    d0 = done_cnt;
    @(posedge clk); #1;
    nonce_base = 0; nonce_limit = 100; start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("abort_start_idle", busy, 0);
    repeat (3) @(posedge clk);
    #2 chk("abort_start_nodone", 64'(done_cnt - d0), 0);

    // watchdog after 4 results
    hit_en = 0; stall_at = 4; err_seen = 0;
    d0 = done_cnt; a0 = abort_cnt;
    do_start(32'd0, 32'd1000, 32'd0);
    wait_done(d0, 2000);
    chk("tmo_error", error, 1);
    chk("tmo_cycles", 64'(err_edge - last_rv), 64'(TIMEOUT));
    chk("tmo_core_abort", 64'(abort_cnt - a0), 1);
    chk("tmo_batches", batches_run, 0);
    stall_at = BATCH;

    // reset mid-sweep
    rnd_h = 1; hseed = $urandom;
    do_start(32'd0, 32'd100000, 32'd0);
    repeat (40) @(posedge clk);
    #3;
    d0 = done_cnt; a0 = abort_cnt;
    reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_core_abort", cif.core_abort, 0);
    chk("mid_rst_core_base", cif.core_nonce_base, 0);
    chk("mid_rst_batches", batches_run, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_found", found, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("mid_rst_no_done", 64'(done_cnt - d0), 0);
    chk("mid_rst_no_abort", 64'(abort_cnt - a0), 0);

    // randomized sweeps, some with a stray start while busy
    for (int k = 0; k < 6; k++) begin
      hseed   = $urandom;
      gap_pct = $urandom_range(0, 50);
      b    = (k == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 200)) : $urandom;
      span = $urandom_range(0, 120);
      l    = (b > 32'hFFFF_FFFF - 32'(span)) ? 32'hFFFF_FFFF : b + 32'(span);
      t    = $urandom_range(0, 32'h0600_0000);
      run_sweep(b, l, t, k[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
